// File: rtl/ika2151_timer.sv
// OPM Timer A (10-bit) and Timer B (8-bit, /16 prescaled) with status flags, IRQ_n and the TA overflow pulse.
// All state advances only on phi1 enabled edges; a tick is an enabled edge with CYCLE_31 high.
module ika2151_timer (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic [9:0] i_TA_VALUE,
  input  logic [7:0] i_TB_VALUE,
  input  logic       i_TA_RUN,
  input  logic       i_TB_RUN,
  input  logic       i_TA_IRQEN,
  input  logic       i_TB_IRQEN,
  input  logic       i_TA_FRST,
  input  logic       i_TB_FRST,
  output logic       o_TA_FLAG,
  output logic       o_TB_FLAG,
  output logic       o_TA_OVFL,
  output logic       o_IRQ_n
);

  logic       ce, tick;
  logic [9:0] ta_cnt, ta_base, ta_next;
  logic [7:0] tb_cnt, tb_base, tb_next;
  logic [3:0] tb_pre, tb_pre_base, tb_pre_next;
  logic       ta_run_q, tb_run_q;
  logic       ta_ovf, tb_ovf;
  logic       ta_flag_next, tb_flag_next;

  assign ce   = ~i_phi1_NCEN_n;
  assign tick = ce & i_CYCLE_31;

  // On the first enabled edge after RUN rises, count from the preset rather
  // than whatever the counter held (e.g. zero straight out of reset).
  always_comb begin
    ta_base = ta_run_q ? ta_cnt : i_TA_VALUE;
    ta_next = ta_base;
    ta_ovf  = 1'b0;
    if (!i_TA_RUN) begin
      ta_next = i_TA_VALUE;
    end else if (tick) begin
      if (ta_base == 10'h3FF) begin
        ta_next = i_TA_VALUE;
        ta_ovf  = 1'b1;
      end else begin
        ta_next = ta_base + 10'd1;
      end
    end
  end

  always_comb begin
    tb_base     = tb_run_q ? tb_cnt : i_TB_VALUE;
    tb_pre_base = tb_run_q ? tb_pre : 4'h0;
    tb_next     = tb_base;
    tb_pre_next = tb_pre_base;
    tb_ovf      = 1'b0;
    if (!i_TB_RUN) begin
      tb_next     = i_TB_VALUE;
      tb_pre_next = 4'h0;
    end else if (tick) begin
      tb_pre_next = tb_pre_base + 4'd1;
      if (tb_pre_base == 4'hF) begin
        if (tb_base == 8'hFF) begin
          tb_next = i_TB_VALUE;
          tb_ovf  = 1'b1;
        end else begin
          tb_next = tb_base + 8'd1;
        end
      end
    end
  end

  // Setting beats a simultaneous flag reset so no overflow event is lost.
  always_comb begin
    ta_flag_next = o_TA_FLAG;
    tb_flag_next = o_TB_FLAG;
    if (ta_ovf && i_TA_IRQEN) ta_flag_next = 1'b1;
    else if (i_TA_FRST)       ta_flag_next = 1'b0;
    if (tb_ovf && i_TB_IRQEN) tb_flag_next = 1'b1;
    else if (i_TB_FRST)       tb_flag_next = 1'b0;
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      ta_cnt    <= 10'h000;
      tb_cnt    <= 8'h00;
      tb_pre    <= 4'h0;
      ta_run_q  <= 1'b0;
      tb_run_q  <= 1'b0;
      o_TA_FLAG <= 1'b0;
      o_TB_FLAG <= 1'b0;
      o_TA_OVFL <= 1'b0;
      o_IRQ_n   <= 1'b1;
    end else if (ce) begin
      ta_cnt    <= ta_next;
      tb_cnt    <= tb_next;
      tb_pre    <= tb_pre_next;
      ta_run_q  <= i_TA_RUN;
      tb_run_q  <= i_TB_RUN;
      o_TA_FLAG <= ta_flag_next;
      o_TB_FLAG <= tb_flag_next;
      o_TA_OVFL <= ta_ovf;
      o_IRQ_n   <= ~(o_TA_FLAG | o_TB_FLAG);
    end
  end

endmodule

// File: tb/tb_ika2151_timer.sv
// Directed bench for ika2151_timer: phi1 enable every second EMUCLK, hand-computed expectations.
module tb_ika2151_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncen, cyc;
  logic [9:0] ta_value;
  logic [7:0] tb_value;
  logic       ta_run, tb_run, ta_irqen, tb_irqen, ta_frst, tb_frst;
  logic       ta_flag, tb_flag, ta_ovfl, irq_n;

  int n_chk  = 0;
  int n_fail = 0;
  int seen;

  always #5 clk = ~clk;

  ika2151_timer dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phi1_NCEN_n (ncen),
    .i_CYCLE_31    (cyc),
    .i_TA_VALUE    (ta_value),
    .i_TB_VALUE    (tb_value),
    .i_TA_RUN      (ta_run),
    .i_TB_RUN      (tb_run),
    .i_TA_IRQEN    (ta_irqen),
    .i_TB_IRQEN    (tb_irqen),
    .i_TA_FRST     (ta_frst),
    .i_TB_FRST     (tb_frst),
    .o_TA_FLAG     (ta_flag),
    .o_TB_FLAG     (tb_flag),
    .o_TA_OVFL     (ta_ovfl),
    .o_IRQ_n       (irq_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One phi1 cycle: a disabled edge, then an enabled edge; sampled 1ns after it.
  task automatic phi1(input logic c31);
    @(negedge clk); ncen = 1'b1; cyc = 1'b0;
    @(negedge clk); ncen = 1'b0; cyc = c31;
    @(posedge clk); #1;
    ncen = 1'b1; cyc = 1'b0;
  endtask

  task automatic tick();
    phi1(1'b0);
    phi1(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ncen = 1'b1; cyc = 1'b0;
    ta_value = '0; tb_value = '0;
    ta_run = 0; tb_run = 0; ta_irqen = 0; tb_irqen = 0; ta_frst = 0; tb_frst = 0;

    // 1: reset held with random inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ncen = 1'($urandom_range(1)); cyc = 1'($urandom_range(1));
      ta_value = 10'($urandom); tb_value = 8'($urandom);
      ta_run = 1'($urandom_range(1)); tb_run = 1'($urandom_range(1));
      ta_irqen = 1'($urandom_range(1)); tb_irqen = 1'($urandom_range(1));
      ta_frst = 1'($urandom_range(1)); tb_frst = 1'($urandom_range(1));
      @(posedge clk); #1;
      chk("reset_outputs", {ta_flag, tb_flag, ta_ovfl, irq_n}, 4'b0001);
    end
    @(negedge clk);
    ncen = 1'b1; cyc = 1'b0; ta_value = '0; tb_value = '0;
    ta_run = 0; tb_run = 0; ta_irqen = 0; tb_irqen = 0; ta_frst = 0; tb_frst = 0;
    rst_n = 1'b1;
    phi1(1'b0);

    // 2: Timer A, NA=3FC, flag enabled
    ta_value = 10'h3FC; ta_run = 1; ta_irqen = 1;
    phi1(1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen += ta_ovfl; end
    chk("ta_no_ovfl_first3", seen, 0);
    tick();
    chk("ta_ovfl_tick4", ta_ovfl, 1'b1);
    chk("ta_flag_set", ta_flag, 1'b1);
    chk("ta_irq_not_yet", irq_n, 1'b1);
    phi1(1'b0);
    chk("ta_ovfl_one_wide", ta_ovfl, 1'b0);
    chk("ta_irq_low", irq_n, 1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen += ta_ovfl; end
    chk("ta_no_ovfl_5to7", seen, 0);
    tick();
    chk("ta_ovfl_tick8", ta_ovfl, 1'b1);
    ta_frst = 1; phi1(1'b0); ta_frst = 0;
    chk("ta_flag_cleared", ta_flag, 1'b0);
    phi1(1'b0);
    chk("ta_irq_released", irq_n, 1'b1);
    ta_run = 0; ta_irqen = 0;
    phi1(1'b0);

    // 3: Timer B, NB=FE -> flag after 32 ticks
    tb_value = 8'hFE; tb_run = 1; tb_irqen = 1;
    phi1(1'b0);
    seen = 0;
    for (int i = 0; i < 31; i++) begin tick(); seen += tb_flag; end
    chk("tb_no_flag_31", seen, 0);
    tick();
    chk("tb_flag_tick32", tb_flag, 1'b1);
    phi1(1'b0);
    chk("tb_irq_low", irq_n, 1'b0);
    tb_frst = 1; phi1(1'b0); tb_frst = 0;
    chk("tb_flag_cleared", tb_flag, 1'b0);
    phi1(1'b0);
    chk("tb_irq_released", irq_n, 1'b1);
    tb_run = 0; tb_irqen = 0;
    phi1(1'b0);

    // 4: NA=3FF, IRQEN=0 -> overflow every tick, no flag
    ta_value = 10'h3FF; ta_run = 1; ta_irqen = 0;
    phi1(1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen += ta_ovfl; end
    chk("ta_ovfl_every_tick", seen, 3);
    chk("ta_flag_irqen0", ta_flag, 1'b0);

    // enabled-low edges only: CYCLE_31 with enable high must do nothing
    @(negedge clk); ncen = 1'b1; cyc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_change_enable_high", ta_ovfl, 1'b1);
    cyc = 1'b0;
    phi1(1'b0);
    chk("ta_ovfl_drops", ta_ovfl, 1'b0);
    ta_run = 0;
    phi1(1'b0);

    // 5: flag set and FRST on the same edge; IRQEN drop keeps flag
    ta_value = 10'h3FC; ta_run = 1; ta_irqen = 1;
    phi1(1'b0);
    for (int i = 0; i < 3; i++) tick();
    ta_frst = 1; tick(); ta_frst = 0;
    chk("set_wins_ovfl", ta_ovfl, 1'b1);
    chk("set_wins_flag", ta_flag, 1'b1);
    ta_irqen = 0; phi1(1'b0);
    chk("irqen_drop_keeps_flag", ta_flag, 1'b1);
    ta_frst = 1; phi1(1'b0); ta_frst = 0;
    chk("flag_clear_after_set_wins", ta_flag, 1'b0);
    ta_run = 0;
    phi1(1'b0);

    // 6: RUN dropped after 2 of 4 ticks, then restarted
    ta_value = 10'h3FC; ta_run = 1; ta_irqen = 1;
    phi1(1'b0);
    tick(); tick();
    ta_run = 0;
    tick();
    chk("stop_no_ovfl", ta_ovfl, 1'b0);
    chk("stop_no_flag", ta_flag, 1'b0);
    ta_run = 1;
    phi1(1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen += ta_ovfl; end
    chk("restart_no_early_ovfl", seen, 0);
    tick();
    chk("restart_ovfl_tick4", ta_ovfl, 1'b1);
    phi1(1'b0);
    chk("restart_irq_low", irq_n, 1'b0);

    // 7: async reset mid-state, then restart from preset
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("async_reset_outputs", {ta_flag, tb_flag, ta_ovfl, irq_n}, 4'b0001);
    ta_run = 0;
    @(negedge clk); rst_n = 1'b1;
    phi1(1'b0);
    ta_run = 1;
    phi1(1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen += ta_ovfl; end
    chk("post_reset_no_early_ovfl", seen, 0);
    tick();
    chk("post_reset_ovfl_tick4", ta_ovfl, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
